// File: rtl/skel_pkg.sv
// Shared types and index helpers for the skeletonization core's image readout path.
package skel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } readout_state_t;

  // Index of the final pixel in an n x n frame.
  function automatic int last_index(input int n);
    return n * n - 1;
  endfunction

  // True when raster index idx is the last column of its row.
  function automatic logic is_eol(input int idx, input int n);
    return (idx % n) == (n - 1);
  endfunction

endpackage

// File: rtl/readout_fifo.sv
// Two-entry register FIFO. Entry 0 is always the head; entry 1 holds the
// second pixel while downstream stalls. The caller never pushes into a
// full FIFO unless it pops in the same cycle.
module readout_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   count_q, count_d;

  // Next-state for the two entries and the occupancy count.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (clear) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = din;
          else                 ent1_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new pixel lands behind whatever remains.
          if (count_q == 2'd1) begin
            ent0_d = din;
          end else begin
            ent0_d = ent1_q;
            ent1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = ent0_q;

endmodule

// File: rtl/image_readout.sv
// Streams the image RAM out in raster order on a valid/ready stream with
// frame and row markers. Reads go through a 1-cycle-latency RAM port; a
// 2-entry FIFO absorbs that latency while downstream stalls.
//
// Output handshake: a pixel transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, with
// out_data and the markers unchanged, until that transfer happens.
module image_readout
  import skel_pkg::*;
#(
  parameter  int N          = 8,
  parameter  int pixelWidth = 8,
  localparam int bitSize    = $clog2(N * N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [bitSize-1:0]    rd_addr,
  input  logic [pixelWidth-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [pixelWidth-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int FW = bitSize + pixelWidth;
  localparam logic [bitSize-1:0] LAST_IDX = bitSize'(last_index(N));

  readout_state_t       state_q, state_d;
  logic [bitSize-1:0]   addr_q, addr_d;
  logic [bitSize-1:0]   idx_q, idx_d;
  logic                 inflight_q, inflight_d;

  logic                 start_ok;
  logic                 pop;
  logic                 push;
  logic [1:0]           fifo_count;
  logic [FW-1:0]        fifo_head;
  logic [bitSize-1:0]   head_idx;
  logic [2:0]           occupancy;

  assign start_ok  = start && (state_q == IDLE || state_q == DONE);
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q;

  // Pixels that will be held after this cycle if no new read is issued.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en     = (state_q == READ) && (occupancy < 3'd2);
  assign rd_addr   = addr_q;

  readout_fifo #(
    .W(FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .push  (push),
    .pop   (pop),
    .din   ({idx_q, rd_data}),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign head_idx = fifo_head[FW-1:pixelWidth];

  // Markers and data are forced low when nothing is presented so stale
  // FIFO contents never leak onto the stream.
  assign out_data = out_valid ? fifo_head[pixelWidth-1:0] : '0;
  assign out_sof  = out_valid && (head_idx == '0);
  assign out_eol  = out_valid && is_eol(int'(head_idx), N);
  assign out_eof  = out_valid && (head_idx == LAST_IDX);

  assign busy = (state_q == READ) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  // FSM next-state plus the address, index and in-flight bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    inflight_d = rd_en;
    if (push)  idx_d  = idx_q + bitSize'(1);
    if (rd_en) addr_d = addr_q + bitSize'(1);
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = READ;
          addr_d     = '0;
          idx_d      = '0;
          inflight_d = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (rd_en && addr_q == LAST_IDX) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && head_idx == LAST_IDX) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_image_readout.sv
// Bench for image_readout: an N=8 instance checked against a queue-based
// reference model every cycle, plus an N=4 one-bit-pixel instance checked
// against hand-written literals.
module tb_image_readout;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- N=8 instance ----------------
  logic       start8, busy8, done8, rd_en8, valid8, ready8;
  logic       sof8, eol8, eof8;
  logic [5:0] rd_addr8;
  logic [7:0] rd_data8, data8;
  logic [7:0] ram8 [64];

  image_readout #(.N(8), .pixelWidth(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8),
    .out_valid(valid8), .out_ready(ready8), .out_data(data8),
    .out_sof(sof8), .out_eol(eol8), .out_eof(eof8)
  );

  always @(posedge clk) if (rd_en8) rd_data8 <= ram8[rd_addr8];

  // ---------------- N=4, 1-bit instance ----------------
  logic       start4, busy4, done4, rd_en4, valid4, ready4;
  logic       sof4, eol4, eof4;
  logic [3:0] rd_addr4;
  logic [0:0] rd_data4, data4;
  logic [0:0] ram4 [16];

  image_readout #(.N(4), .pixelWidth(1)) u4 (
    .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .out_valid(valid4), .out_ready(ready4), .out_data(data4),
    .out_sof(sof4), .out_eol(eol4), .out_eof(eof4)
  );

  always @(posedge clk) if (rd_en4) rd_data4 <= ram4[rd_addr4];

  // ---------------- scoreboard state ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         got = 0;        // transfers seen in the current frame
  int         rd_cnt = 0;     // reads issued in the current frame
  int         done_cnt = 0;
  int         e0 = 0;         // edge at which start was sampled
  bit         tmode = 1'b0;   // exact-cycle checks (full-rate frame)
  bit         prev_stall = 1'b0;
  logic [10:0] prev_bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- per-cycle compare (N=8) ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      exp_q.delete();
      got = 0;
      rd_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      if (tmode && cyc == e0)
        check("start_latency", {busy8, rd_en8, 2'b00, rd_addr8}, {1'b1, 1'b1, 8'h00});
      if (prev_stall)
        check("hold_stable", {valid8, data8, sof8, eol8, eof8}, {1'b1, prev_bus});
      if (rd_en8) begin
        check("rd_addr_seq", 32'(rd_addr8), rd_cnt);
        rd_cnt++;
      end
      if (valid8 && ready8) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'(data8), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pixel_data", 32'(data8), 32'(e));
          check("markers", {sof8, eol8, eof8},
                {got == 0, (got % 8) == 7, got == 63});
          if (tmode) check("xfer_edge", cyc + 1 - e0, 3 + got);
        end
        got++;
      end
      if (rd_en8) check("outstanding_le3", (rd_cnt - got) <= 3, 1);
      if (done8) begin
        done_cnt++;
        check("busy_at_done", busy8, 0);
        if (tmode) check("done_cycle", cyc - e0, 66);
      end
      prev_stall = valid8 && !ready8;
      prev_bus   = {data8, sof8, eol8, eof8};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic kick();
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(ram8[i]);
    got = 0;
    rd_cnt = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    start8 = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: toggling ready with random 5-cycle stalls.
  task automatic run_frame(input int mode, input int restart_at);
    int stall = 0;
    bit restarted = 1'b0;
    bit ok = 1'b0;
    kick();
    for (int c = 0; c < 1000; c++) begin
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
      if (mode == 1) begin
        if (stall > 0) begin
          ready8 = 1'b0;
          stall--;
        end else if ($urandom_range(0, 11) == 0) begin
          ready8 = 1'b0;
          stall = 4;
        end else begin
          ready8 = ~ready8;
        end
      end else begin
        ready8 = 1'b1;
      end
      if (restart_at >= 0 && !restarted && got == restart_at) begin
        start8 = 1'b1;
        restarted = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    ready8 = 1'b1;
    check("frame_finished", ok, 1);
    check("pixel_count", got, 64);
    check("model_drained", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
    check("single_done", done_cnt, 1);
    check("idle_after", {valid8, busy8}, 0);
  endtask

  task automatic check_reset_vals(input string name);
    check(name, {busy8, done8, rd_en8, valid8, sof8, eol8, eof8, rd_addr8, data8}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] pat4;
    logic [15:0] eol4_mask;
    int  k;
    bit  seen;
    pat4      = 16'h5555;  // 1,0,1,0,... starting at index 0
    eol4_mask = 16'h8888;  // indices 3, 7, 11, 15
    rst = 1'b1;
    start8 = 1'b0; ready8 = 1'b1;
    start4 = 1'b0; ready4 = 1'b1;
    for (int i = 0; i < 16; i++) ram4[i] = pat4[i];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_vals");
    check("reset_vals_n4", {busy4, done4, rd_en4, valid4, sof4, eol4, eof4, rd_addr4, data4}, 0);

    // Full-rate frame, exact timing.
    for (int i = 0; i < 64; i++) ram8[i] = 8'(i);
    tmode = 1'b1;
    run_frame(0, -1);
    tmode = 1'b0;

    // Backpressure.
    run_frame(1, -1);

    // Start while busy is ignored.
    for (int i = 0; i < 64; i++) ram8[i] = 8'(i * 3 + 1);
    run_frame(0, 20);

    // Reset mid-frame after pixel 30's handshake.
    for (int i = 0; i < 64; i++) ram8[i] = 8'(255 - i);
    kick();
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (got == 31) begin
        seen = 1'b1;
        break;
      end
    end
    check("reached_pixel30", seen, 1);
    rst = 1'b1;
    ready8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ready8 = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_mid_frame");
    repeat (5) begin
      @(negedge clk);
      check("no_xfer_after_reset", {valid8, rd_en8, busy8}, 0);
    end
    for (int i = 0; i < 64; i++) ram8[i] = 8'(i);
    run_frame(0, -1);

    // N=4, 1-bit pixels, full rate.
    @(posedge clk); #1;
    start4 = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    start4 = 1'b0;
    k = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (valid4 && ready4) begin
        if (k < 16) begin
          check("n4_data", data4, pat4[k]);
          check("n4_eol", eol4, eol4_mask[k]);
          check("n4_sof_eof", {sof4, eof4}, {k == 0, k == 15});
          check("n4_xfer_edge", cyc + 1 - e0, 3 + k);
        end
        k++;
      end
      if (done4 && !seen) begin
        seen = 1'b1;
        check("n4_done_cycle", cyc - e0, 18);
        check("n4_count", k, 16);
        check("n4_busy_at_done", busy4, 0);
      end
    end
    check("n4_done_seen", seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/image_readout.md
# image_readout

Streams the processed image back out of the skeletonization core's image RAM, one pixel at a time, in raster order. It is the reader counterpart to the pixel write-in path, which loads `N*N` pixels through `we`/`data_in`. After the core finishes, a `start` pulse makes this block walk RAM addresses `0..N*N-1` through a 1-cycle-latency read port. It presents each pixel on a valid/ready output stream with frame and row markers, and absorbs RAM latency under backpressure with a 2-entry buffer.

## Interface
Parameters:
- `N`, 8: image side length; the frame is `N*N` pixels.
- `pixelWidth`, 8: bits per pixel.
- `bitSize`, `$clog2(N*N)`: address and index width. Derived only; never set manually.

Ports:
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: 1-cycle request to read one frame. Accepted only in IDLE or DONE.
- `busy`  out  1: high from the cycle after `start` is accepted until the last pixel is handshaken.
- `done`  out  1: 1-cycle pulse after the final pixel handshake.
- `rd_en`  out  1: RAM read request.
- `rd_addr`  out  `bitSize`: RAM read address.
- `rd_data`  in  `pixelWidth`: RAM data, valid the cycle after `rd_en`.
- `out_valid`  out  1: output pixel valid.
- `out_ready`  in  1: downstream accept.
- `out_data`  out  `pixelWidth`: pixel value.
- `out_sof`  out  1: marks pixel index 0.
- `out_eol`  out  1: marks the last pixel of a row (`col == N-1`).
- `out_eof`  out  1: marks pixel index `N*N-1`.

## Operation
- States: IDLE, READ, DRAIN, DONE.
  - IDLE/DONE → READ on `start`. This clears the address counter, the index counter and the buffer.
  - READ → DRAIN after the read of address `N*N-1` is issued.
  - DRAIN → DONE on the handshake of index `N*N-1`.
  - DONE → IDLE after one cycle; `done`=1 during that cycle.
- Issuing reads:
  - `rd_en` is combinational: `state==READ && (count + inflight - pop) < 2`.
  - `pop` = `out_valid && out_ready`; `inflight` is a 1-bit flag meaning a read was issued last cycle.
  - `rd_addr` = address counter. The counter increments on each `rd_en` and never wraps within a frame.
- Buffer:
  - When `inflight`, `rd_data` is written to the buffer together with its pixel index.
  - `out_*` are driven from the buffer head. `out_sof`, `out_eol` and `out_eof` are decoded from the stored index.
- Handshake rules:
  - Transfer occurs when `out_valid && out_ready`.
  - `out_data` and the markers stay stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a transfer.
- Simultaneous push and pop on a full buffer is legal; the count stays at 2.
- `start` while busy is ignored: no restart, no side effects.
- Reset in any state gives: state IDLE, all counters 0, buffer empty, `inflight`=0. Any in-flight RAM data is discarded.
- Reset values: `busy`, `done`, `rd_en`, `out_valid`, `out_sof`, `out_eol`, `out_eof` = 0. `rd_addr` = 0. `out_data` = 0.

## Timing
- Start latency: `start` sampled at edge E0. `rd_en` is high with `rd_addr`=0 in the following cycle; data is buffered at E2; `out_valid` is first high after E2.
- With `out_ready` tied high, throughput is 1 pixel/cycle. Pixel k handshakes at E(3+k); for N=8 the last handshake is at E66, and `done` is high in the cycle after E66.
- `busy` falls in the same cycle that `done` rises.
- Downstream stalls never lose or duplicate pixels. At most 2 pixels are buffered plus 1 read in flight.

## Structure
- Shared package `skel_pkg` holds:
  - the `readout_state_t` enum (IDLE/READ/DRAIN/DONE);
  - a function for last-index (`N*N-1`) and end-of-line decode.
- Sub-module `readout_fifo`: a 2-entry register FIFO parameterized on width. It stores `{index, pixel}` and exposes `push`, `pop`, `count`, and `head`.
- The top level holds the FSM, address counter and `inflight` flag.

## Test plan
- Full-rate frame: RAM loaded with `pixel[i] = i`, N=8, `out_ready`=1, `start` at E0.
  - Expect 64 transfers with `out_data` 0..63 at E3..E66.
  - `out_sof` on pixel 0 only; `out_eol` on 7, 15, …, 63; `out_eof` on 63 only.
  - `done` pulses once, in the cycle after E66.
- Backpressure: `out_ready` toggles 1,0,1,0… with random 5-cycle stalls.
  - Sequence is still exactly 0..63, held stable while stalled.
  - `rd_en` never issues when the buffer plus in-flight count would exceed 2.
- Start while busy: a second `start` pulse at pixel 20 is ignored. Exactly 64 pixels are output and there is one `done`.
- Reset mid-frame: `rst` asserted after pixel 30's handshake.
  - Next cycle: all outputs at reset values and no further transfers.
  - A new `start` then yields a clean frame beginning at 0 with `out_sof`.
- Parameter variant N=4, pixelWidth=1, binary image pattern 1010…: 16 pixels, `out_eol` on indices 3, 7, 11, 15, and `done` in the cycle after E18.
